// File: rtl/dechop_hold.sv
// dechop_hold: frame-aligned chopper removal with per-channel hold of the last good sample.
// Optional macro DECHOP_SAT_EN: saturate the negation of the most negative sample.
module dechop_hold #(
    parameter int N_CH = 16,
    parameter int DW   = 18
) (
    input  logic                 adc_data_clk,
    input  logic                 reset_n,
    input  logic                 chop_en,
    input  logic                 chop_dly_i,
    input  logic                 data_hold_i,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    output logic [4:0]           out_chan,
    output logic signed [DW-1:0] out_data,
    output logic                 out_held,
    output logic                 frame_err
);
    typedef enum logic [1:0] {S_WAIT, S_RUN, S_OVER} state_t;

    state_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic en_q, en_d, chop_q, chop_d, hold_q, hold_d;
    logic s1_v_q, s1_v_d, s1_held_q, s1_held_d;
    logic [4:0] s1_chan_q, s1_chan_d;
    logic signed [DW-1:0] s1_data_q, s1_data_d;
    logic ov_q, ov_d, oh_q, oh_d, err_q, err_d;
    logic [4:0] oc_q, oc_d;
    logic signed [DW-1:0] od_q, od_d, neg, lg_rd;
    logic signed [DW-1:0] lg_q [N_CH];
    logic signed [DW-1:0] lg_d [N_CH];
    logic first, acc, over, e_en, e_chop, e_hold;

    always_comb begin
        first  = in_valid && in_first;
        acc    = first || (in_valid && state_q == S_RUN && cnt_q < 6'(N_CH));
        over   = in_valid && !in_first && state_q == S_RUN && cnt_q == 6'(N_CH);
        // The frame's first sample must already see its own newly latched flags
        e_en   = first ? chop_en     : en_q;
        e_chop = first ? chop_dly_i  : chop_q;
        e_hold = first ? data_hold_i : hold_q;
`ifdef DECHOP_SAT_EN
        neg = (in_data == {1'b1, {(DW-1){1'b0}}}) ? ~in_data : -in_data;
`else
        neg = -in_data;
`endif
        state_d   = first ? S_RUN : over ? S_OVER : state_q;
        cnt_d     = first ? 6'd1 : acc ? cnt_q + 6'd1 : cnt_q;
        en_d      = e_en;
        chop_d    = e_chop;
        hold_d    = e_hold;
        s1_v_d    = acc;
        s1_chan_d = first ? 5'd0 : cnt_q[4:0];
        s1_data_d = (e_en && e_chop) ? neg : in_data;
        s1_held_d = e_en && e_hold;
        lg_rd = '0;
        lg_d  = lg_q;
        for (int i = 0; i < N_CH; i++) begin
            if (s1_chan_q == 5'(i)) begin
                lg_rd = lg_q[i];
                if (s1_v_q && !s1_held_q) lg_d[i] = s1_data_q;
            end
        end
        ov_d  = s1_v_q;
        oc_d  = s1_v_q ? s1_chan_q : oc_q;
        od_d  = s1_v_q ? (s1_held_q ? lg_rd : s1_data_q) : od_q;
        oh_d  = s1_v_q ? s1_held_q : oh_q;
        err_d = err_q || over;
    end

    always_ff @(posedge adc_data_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            chop_q    <= 1'b0;
            hold_q    <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_chan_q <= '0;
            s1_data_q <= '0;
            s1_held_q <= 1'b0;
            ov_q      <= 1'b0;
            oc_q      <= '0;
            od_q      <= '0;
            oh_q      <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) lg_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            chop_q    <= chop_d;
            hold_q    <= hold_d;
            s1_v_q    <= s1_v_d;
            s1_chan_q <= s1_chan_d;
            s1_data_q <= s1_data_d;
            s1_held_q <= s1_held_d;
            ov_q      <= ov_d;
            oc_q      <= oc_d;
            od_q      <= od_d;
            oh_q      <= oh_d;
            err_q     <= err_d;
            lg_q      <= lg_d;
        end
    end

    assign out_valid = ov_q;
    assign out_chan  = oc_q;
    assign out_data  = od_q;
    assign out_held  = oh_q;
    assign frame_err = err_q;
endmodule

// File: tb/tb_dechop_hold.sv
// tb_dechop_hold: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_dechop_hold;
    localparam int N = 16;
    localparam int DW = 18;
`ifdef DECHOP_SAT_EN
    localparam int SATV = 131071;
`else
    localparam int SATV = -131072;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic chop_en = 1'b0, chop = 1'b0, hold = 1'b0, iv = 1'b0, ifst = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic ov, oh, ferr;
    logic [4:0] oc;
    logic signed [DW-1:0] od;

    dechop_hold #(.N_CH(N), .DW(DW)) dut (
        .adc_data_clk(clk), .reset_n(rst_n), .chop_en(chop_en), .chop_dly_i(chop),
        .data_hold_i(hold), .in_valid(iv), .in_first(ifst), .in_data(din),
        .out_valid(ov), .out_chan(oc), .out_data(od), .out_held(oh), .frame_err(ferr)
    );

    always #6 clk = ~clk;

    typedef struct {int ch; int d; int h; int due;} exp_t;
    exp_t q[$];
    int cyc = 0, n_cmp = 0, n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ov) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_chan", int'(oc), e.ch);
                chk("out_data", int'(od), e.d);
                chk("out_held", int'(oh), e.h);
                chk("latency", cyc, e.due);
            end
        end
    end

    task automatic send(input logic f, input int d, input logic acc, input int ch, input int ed, input int eh);
        iv = 1'b1;
        ifst = f;
        din = DW'(d);
        if (acc) q.push_back('{ch, ed, eh, cyc + 2});
        @(posedge clk); #1;
        iv = 1'b0;
        ifst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("drain", q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, int'(ov), 0);
        chk({tag, "_out_chan"}, int'(oc), 0);
        chk({tag, "_out_data"}, int'(od), 0);
        chk({tag, "_out_held"}, int'(oh), 0);
        chk({tag, "_frame_err"}, int'(ferr), 0);
    endtask

    initial begin
        int d;
        idle(3);
        chk_zero("reset");
        rst_n = 1'b1;
        idle(1);
        send(1'b0, 77, 1'b0, 0, 0, 0);
        // Pass-through frame: flags ignored with chop_en low, last_good still updated
        chop_en = 1'b0; chop = 1'b1; hold = 1'b1;
        for (int c = 0; c < N; c++) send(c == 0, c * 100, 1'b1, c, c * 100, 0);
        chop_en = 1'b1; chop = 1'b1; hold = 1'b0;
        for (int c = 0; c < N; c++) begin
            d = (c == 0) ? -131072 : (c == 3) ? 1234 : c * 10 + 7;
            send(c == 0, d, 1'b1, c, (c == 0) ? SATV : -d, 0);
            chop_en = 1'b0; chop = 1'b0; hold = 1'b1;
        end
        chop_en = 1'b1; chop = 1'b0; hold = 1'b0;
        for (int c = 0; c < N; c++) begin
            d = (c == 5) ? 500 : c * 3;
            send(c == 0, d, 1'b1, c, d, 0);
            hold = 1'b1;
        end
        // Short held frame with gaps: outputs come from the previous frame's values
        chop_en = 1'b1; chop = 1'b1; hold = 1'b1;
        for (int c = 0; c < 8; c++) begin
            send(c == 0, (c == 5) ? -9000 : 55, 1'b1, c, (c == 5) ? 500 : c * 3, 1);
            if (c == 3) idle(2);
        end
        drain();
        chk("frame_err_short", int'(ferr), 0);
        chop_en = 1'b0; chop = 1'b0; hold = 1'b0;
        for (int c = 0; c < N; c++) send(c == 0, c + 1, 1'b1, c, c + 1, 0);
        send(1'b0, 999, 1'b0, 0, 0, 0);
        send(1'b0, 888, 1'b0, 0, 0, 0);
        drain();
        chk("frame_err_set", int'(ferr), 1);
        chop_en = 1'b1; chop = 1'b1; hold = 1'b0;
        for (int c = 0; c < 4; c++) send(c == 0, c * 1000 + 1, 1'b1, c, -(c * 1000 + 1), 0);
        drain();
        chk("frame_err_sticky", int'(ferr), 1);
        chop_en = 1'b0;
        for (int c = 0; c < 8; c++) send(c == 0, c + 50, 1'b1, c, c + 50, 0);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk_zero("midreset");
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send(1'b0, 123, 1'b0, 0, 0, 0);
        chop_en = 1'b1; chop = 1'b0; hold = 1'b1;
        for (int c = 0; c < 8; c++) send(c == 0, c + 300, 1'b1, c, 0, 1);
        drain();
        chk("frame_err_after_reset", int'(ferr), 0);
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
